afe_tx_iq_mux: RTL



---
 rtl/sdr_pkg.sv | 27 ++
 rtl/afe_tx_fifo.sv | 60 ++++++
 rtl/afe_tx_iq_mux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Shared AFE sample definitions: I/Q widths, TX state encoding and the
// two's-complement / offset-binary word conversion used on the AFE pins.
package sdr_pkg;

    localparam int IQ_PAIR_WIDTH = 24;
    localparam int SAMPLE_WIDTH  = IQ_PAIR_WIDTH / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } tx_state_t;

    // Offset-binary differs from two's complement only in the sign bit.
    function automatic logic [SAMPLE_WIDTH-1:0] to_afe_code(
        input logic [SAMPLE_WIDTH-1:0] sample,
        input logic                    offset_binary
    );
        to_afe_code = {sample[SAMPLE_WIDTH-1] ^ offset_binary, sample[SAMPLE_WIDTH-2:0]};
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] zero_code(input logic offset_binary);
        zero_code = to_afe_code({SAMPLE_WIDTH{1'b0}}, offset_binary);
    endfunction

endpackage

// File: rtl/afe_tx_fifo.sv
// Small synchronous pair FIFO with a registered occupancy count; a word
// written this cycle is not readable until the next one.
module afe_tx_fifo
    import sdr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = IQ_PAIR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/afe_tx_iq_mux.sv
// Buffers host I/Q pairs and interleaves them onto the 12-bit AFE TX bus as
// I then Q words, inserting zero-coded pairs and flagging underruns when starved.
module afe_tx_iq_mux
    import sdr_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int PRIME_LEVEL   = 2,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [IQ_PAIR_WIDTH-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [SAMPLE_WIDTH-1:0]       afe_tx_d,
    output logic                          afe_tx_sel,
    output logic                          afe_tx_en,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SAMPLE_WIDTH-1:0] ZERO = zero_code(OFFSET_BINARY);

    tx_state_t                state;
    tx_state_t                state_next;
    logic                     ph;
    logic [SAMPLE_WIDTH-1:0]  q_hold;
    logic [SAMPLE_WIDTH-1:0]  q_next;
    logic [SAMPLE_WIDTH-1:0]  d_next;
    logic                     sel_next;
    logic                     txen_next;
    logic                     und_next;
    logic [15:0]              cnt_q;
    logic [IQ_PAIR_WIDTH-1:0] fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     push;
    logic                     pop;

    assign s_ready      = ~reset & ~fifo_full;
    assign push         = s_valid & s_ready;
    assign pop          = (state == ST_RUN) & ~ph & ~fifo_empty;
    assign underrun_cnt = cnt_q;

    afe_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IQ_PAIR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_FLUSH: state_next = ST_IDLE;
            ST_IDLE:  if (en) state_next = ST_PRIME;
            ST_PRIME: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (fifo_level >= LW'(PRIME_LEVEL)) begin
                    state_next = ST_RUN;
                end
            end
            // Leaving only from the Q slot keeps every pair intact.
            ST_RUN:   if (ph && !en) state_next = ST_IDLE;
            default:  state_next = ST_FLUSH;
        endcase
    end

    always_comb begin
        d_next    = ZERO;
        sel_next  = 1'b0;
        txen_next = 1'b0;
        und_next  = 1'b0;
        q_next    = q_hold;
        if (state == ST_RUN) begin
            txen_next = 1'b1;
            if (!ph) begin
                sel_next = 1'b1;
                if (fifo_empty) begin
                    und_next = 1'b1;
                    q_next   = ZERO;
                end else begin
                    d_next = to_afe_code(fifo_rdata[IQ_PAIR_WIDTH-1:SAMPLE_WIDTH], OFFSET_BINARY);
                    q_next = to_afe_code(fifo_rdata[SAMPLE_WIDTH-1:0], OFFSET_BINARY);
                end
            end else begin
                d_next = q_hold;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FLUSH;
            ph         <= 1'b0;
            q_hold     <= ZERO;
            afe_tx_d   <= ZERO;
            afe_tx_sel <= 1'b0;
            afe_tx_en  <= 1'b0;
            underrun   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_next;
            ph         <= (state == ST_RUN) ? ~ph : 1'b0;
            q_hold     <= q_next;
            afe_tx_d   <= d_next;
            afe_tx_sel <= sel_next;
            afe_tx_en  <= txen_next;
            underrun   <= und_next;
            if (und_next && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

endmodule
